// File: rtl/binary_to_grey_sync_grey_to_binary_top_pkg.sv
// Shared defaults and Gray-code helpers for the pointer synchronizer.
// Helpers work at MAX_WIDTH; narrower pointers are zero-extended in and truncated out.
package binary_to_grey_sync_grey_to_binary_top_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 3;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int MAX_WIDTH           = 16;

    typedef logic [MAX_WIDTH-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended upper Gray bits decode to zero, so the full-width decode is exact.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Cascade of STAGES flops that carries a Gray-coded pointer into the clk_in domain.
// Nothing but flops sits in the chain, so only one bit can be in flight per change.
module gray_sync_chain #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

    // NOTE: these are individual flops, not a RAM, so every stage is cleared on reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= d_in;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q_out = stage[STAGES-1];

endmodule

// File: rtl/binary_to_grey_sync_grey_to_binary_top.sv
// Binary pointer from a foreign domain -> Gray encode -> flop chain -> binary decode.
// The only path from input to output runs through the synchronizer flops.
module binary_to_grey_sync_grey_to_binary_top
    import binary_to_grey_sync_grey_to_binary_top_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [ADDR_WIDTH-1:0] binary_ptr_in,
    output logic [ADDR_WIDTH-1:0] binary_ptr_out
);

    logic [ADDR_WIDTH-1:0] gray;
    logic [ADDR_WIDTH-1:0] sync_gray;

    assign gray = ADDR_WIDTH'(bin2gray(ptr_t'(binary_ptr_in)));

    gray_sync_chain #(
        .WIDTH  (ADDR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .d_in     (gray),
        .q_out    (sync_gray)
    );

    assign binary_ptr_out = ADDR_WIDTH'(gray2bin(ptr_t'(sync_gray)));

endmodule

// File: tb/tb_binary_to_grey_sync_grey_to_binary_top.sv
// Bench for the Gray pointer synchronizer: directed table, random vs. model,
// exhaustive holds on 1/3/4-bit instances, and an unrelated-clock source.
`timescale 1ns/1ps
module tb_binary_to_grey_sync_grey_to_binary_top;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic [2:0] in3;
    logic [3:0] in4;
    logic [0:0] in1;
    logic [2:0] out3;
    logic [3:0] out4;
    logic [0:0] out1;

    int checks = 0;
    int errors = 0;

    // Model: the output shows the input sampled two edges earlier; reset zeroes history.
    int model_q[$] = '{0, 0};

    typedef struct {
        logic       rst;
        logic [2:0] in;
        logic [2:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[$];

    always #50 clk_in = ~clk_in;

    binary_to_grey_sync_grey_to_binary_top dut3 (
        .clk_in(clk_in), .reset_in(reset_in), .binary_ptr_in(in3), .binary_ptr_out(out3));

    binary_to_grey_sync_grey_to_binary_top #(.ADDR_WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .clk_in(clk_in), .reset_in(reset_in), .binary_ptr_in(in4), .binary_ptr_out(out4));

    binary_to_grey_sync_grey_to_binary_top #(.ADDR_WIDTH(1), .SYNC_STAGES(3)) dut1 (
        .clk_in(clk_in), .reset_in(reset_in), .binary_ptr_in(in1), .binary_ptr_out(out1));

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        if (reset_in) begin
            model_q = '{0, 0};
        end else begin
            model_q.push_back(int'(in3));
            void'(model_q.pop_front());
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int prev1;
        int prev3;
        int changes;

        reset_in = 1'b0;
        in3 = '0;
        in4 = '0;
        in1 = '0;

        // Reset with input 5, release, then step 0 -> 6.
        vecs.push_back('{1'b1, 3'd5, 3'd0, "reset_edge1"});
        vecs.push_back('{1'b1, 3'd5, 3'd0, "reset_edge2"});
        vecs.push_back('{1'b0, 3'd5, 3'd0, "reset_release1"});
        vecs.push_back('{1'b0, 3'd5, 3'd5, "reset_release2"});
        vecs.push_back('{1'b0, 3'd0, 3'd5, "step_pre1"});
        vecs.push_back('{1'b0, 3'd0, 3'd0, "step_pre2"});
        vecs.push_back('{1'b0, 3'd6, 3'd0, "step_edge1"});
        vecs.push_back('{1'b0, 3'd6, 3'd6, "step_edge2"});
        // Sweep 0..7,0,1: output trails by two edges, through the 7->0 wrap.
        for (int i = 0; i < 10; i++) begin
            vec_t v;
            v.rst  = 1'b0;
            v.in   = 3'(i % 8);
            v.exp  = (i == 0) ? 3'd6 : 3'((i - 1) % 8);
            v.name = "sweep";
            vecs.push_back(v);
        end
        vecs.push_back('{1'b0, 3'd1, 3'd1, "sweep_tail"});
        // Mid-operation reset while input is 3.
        vecs.push_back('{1'b0, 3'd3, 3'd1, "midrst_pre1"});
        vecs.push_back('{1'b0, 3'd3, 3'd3, "midrst_pre2"});
        vecs.push_back('{1'b1, 3'd3, 3'd0, "midrst_edge"});
        vecs.push_back('{1'b0, 3'd3, 3'd0, "midrst_release1"});
        vecs.push_back('{1'b0, 3'd3, 3'd3, "midrst_release2"});

        foreach (vecs[i]) begin
            reset_in = vecs[i].rst;
            in3      = vecs[i].in;
            tick();
            check(vecs[i].name, int'(out3), int'(vecs[i].exp));
        end
        reset_in = 1'b0;

        // Random stimulus with occasional resets against the model.
        for (int i = 0; i < 200; i++) begin
            reset_in = ($urandom_range(15) == 0);
            in3      = 3'($urandom_range(7));
            tick();
            check("random", int'(out3), model_q[0]);
        end
        reset_in = 1'b0;

        // Exhaustive holds; dut1 has three stages, so its value lands one edge later.
        in3 = '0;
        in4 = '0;
        in1 = '0;
        repeat (3) tick();
        prev1 = 0;
        for (int v = 0; v < 16; v++) begin
            in4 = 4'(v);
            in3 = 3'(v % 8);
            in1 = 1'(v % 2);
            tick();
            tick();
            check("exh3_latency2", int'(out3), v % 8);
            check("exh1_still_old", int'(out1), prev1);
            tick();
            check("exh4_out", int'(out4), v);
            check("exh4_stage0", int'(dut4.u_sync_chain.stage[0]), v ^ (v >> 1));
            check("exh3_stage0", int'(dut3.u_sync_chain.stage[0]), (v % 8) ^ ((v % 8) >> 1));
            check("exh1_out", int'(out1), v % 2);
            check("exh1_stage0", int'(dut1.u_sync_chain.stage[0]), v % 2);
            prev1 = v % 2;
        end

        // Pointer incremented from an unrelated 150-unit clock against the 100-unit clk_in.
        prev3   = int'(out3);
        changes = 0;
        fork
            begin
                #36;
                for (int i = 0; i < 40; i++) begin
                    in3 = in3 + 3'd1;
                    #150;
                end
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    @(posedge clk_in);
                    #1;
                    if (int'(out3) != prev3) begin
                        check("async_step", int'(out3), (prev3 + 1) % 8);
                        prev3 = int'(out3);
                        changes++;
                    end
                end
            end
        join
        check("async_change_count", changes, 40);
        check("async_final", int'(out3), (7 + 40) % 8);

        reset_in = 1'b1;
        tick();
        check("final_reset", int'(out3), 0);
        reset_in = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/binary_to_grey_sync_grey_to_binary_top.md
BINARY_TO_GREY_SYNC_GREY_TO_BINARY_TOP -- requirements
Module: binary_to_grey_sync_grey_to_binary_top

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; the clock is clk_in and the reset is reset_in.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 3: pointer width in bits, legal range 1..16.
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops, legal range 2..4.
REQ-004 The module SHALL have port clk_in, input, 1 bit: destination-domain clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset_in, input, 1 bit: synchronous, active-high, destination-domain reset.
REQ-006 The module SHALL have port binary_ptr_in, input, ADDR_WIDTH bits: binary pointer driven from the foreign clock domain; it may change at any time.
REQ-007 The module SHALL have port binary_ptr_out, output, ADDR_WIDTH bits: the pointer resynchronized into the clk_in domain, in binary.

Function
REQ-008 The module SHALL encode binary_ptr_in combinationally to Gray code: gray = bin XOR (bin >> 1).
REQ-009 The Gray value SHALL pass through exactly SYNC_STAGES cascaded flops clocked by clk_in; stage 0 samples the encoded Gray value, and each stage k samples stage k-1.
REQ-010 binary_ptr_out SHALL be the combinational Gray-to-binary decode of the last stage: b[MSB] = g[MSB]; b[i] = b[i+1] XOR g[i] for i below MSB.
REQ-011 No other logic SHALL sit between the encoder and stage 0, or between stages.
REQ-012 Latency: an input held stable across SYNC_STAGES consecutive rising edges SHALL appear on binary_ptr_out immediately after the SYNC_STAGES-th edge (2 edges by default).
REQ-013 For any stable input v, decode(encode(v)) SHALL equal v for all 2^ADDR_WIDTH values.
REQ-014 Wrap-around from 2^ADDR_WIDTH-1 to 0 SHALL change exactly one Gray bit (for example, 3'b100 to 3'b000), and the output SHALL wrap from 7 to 0 with no intermediate value.
REQ-015 For an input that increments by one, the output SHALL only ever show the old value or the new value, never any other code, provided the input changes at most once per sampling window.
REQ-016 For ADDR_WIDTH = 1, the Gray code and binary code SHALL be identical.
REQ-017 The design SHALL have no enable, no handshake and no combinational path from binary_ptr_in to binary_ptr_out.

Reset
REQ-018 On a rising edge of clk_in with reset_in = 1, all synchronizer stages SHALL load 0, so binary_ptr_out = 0 after that edge.
REQ-019 Reset SHALL take priority over sampling, including when reset is asserted mid-operation.
REQ-020 After reset deasserts, the current input SHALL reach the output after SYNC_STAGES further edges.
REQ-021 The output before the first reset edge SHALL be undefined, and the bench SHALL not check it.

Structure
REQ-022 A shared package SHALL hold the ADDR_WIDTH and SYNC_STAGES defaults and the pure functions bin2gray and gray2bin, each generic over width through a parameterized width or a maximum-width argument.
REQ-023 The flop chain SHALL be a single sub-module, gray_sync_chain, with parameters WIDTH and STAGES and ports clk_in, reset_in, d_in and q_out.
REQ-024 The top module SHALL contain only the encoder, one gray_sync_chain instance and the decoder.
REQ-025 The synchronizer flops SHALL carry the codebase's async-register attribute so that synthesis keeps them adjacent and unretimed.

Verification
REQ-026 Scenario, reset: hold reset_in = 1 for 2 edges with input 5 -> output 0 throughout reset and on the first edge after release; output 5 after the second edge.
REQ-027 Scenario, step: from 0, set input to 6 between edges -> output remains 0 after edge 1 and becomes 6 after edge 2; no other value appears.
REQ-028 Scenario, sweep: increment the input 0,1,...,7,0,1 once per clk_in cycle -> output repeats the same sequence delayed by exactly 2 cycles, including the 7->0 wrap.
REQ-029 Scenario, mid-operation reset: input 3 stable, assert reset_in for one edge -> output 0 on that edge; after release, output 3 two edges later.
REQ-030 Scenario, exhaustive: for ADDR_WIDTH = 3 and 4, hold each value v for 3 cycles -> output equals v, and the internal stage-0 value equals v ^ (v >> 1).
REQ-031 Scenario, asynchronous source: drive a Gray-incrementing pointer from an unrelated 100/150-unit clock ratio -> every output change is +1 modulo 2^ADDR_WIDTH.
